instruction_fetch_stage: RTL and testbench

Fetch stage of the RISC-V core: owns the program counter, drives `Inst_Address` into `Instruction_Memory`, and captures the returned `Instruction` into the IF/ID pipeline register.
- Handles stall (hold), branch redirect (flush the fetched instruction), end-of-program halt and misaligned-target error.
- Sits between the branch/hazard logic and the decode stage.

---
 rtl/instruction_fetch_stage_pkg.sv | 35 +++
 rtl/instruction_fetch_stage_if.sv | 17 +
 rtl/instruction_fetch_stage_if_id_register.sv | 58 +++++
 rtl/instruction_fetch_stage.sv | 140 ++++++++++++++
 tb/tb_instruction_fetch_stage.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the instruction fetch stage.
//   XLEN / ILEN     : address and instruction widths
//   NOP_INST        : canonical bubble (addi x0,x0,0)
//   fetch_state_t   : fetch FSM states
//   ifid_op_t       : IF/ID register control (hold / load / flush)
//   past_end()      : true when an address lies beyond the last fetchable word
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      ERR  = 2'd2
   } fetch_state_t;

   typedef enum logic [1:0] {
      IFID_HOLD  = 2'd0,
      IFID_LOAD  = 2'd1,
      IFID_FLUSH = 2'd2
   } ifid_op_t;

   // An address is unfetchable once it is strictly above the last word address.
   function automatic logic past_end(input logic [XLEN-1:0] addr,
                                     input logic [XLEN-1:0] last_addr);
      return (addr > last_addr);
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage_if
// Instruction-memory bus between the fetch stage and Instruction_Memory.
//   Inst_Address : fetch address (driven by the fetch stage)
//   Instruction  : instruction word returned combinationally by memory
// Modports: master = fetch stage, slave = instruction memory.
// ---------------------------------------------------------------------------
interface instruction_fetch_stage_if;
   import riscv_pkg::*;

   logic [XLEN-1:0] Inst_Address;
   logic [ILEN-1:0] Instruction;

   modport master (output Inst_Address, input Instruction);
   modport slave  (input Inst_Address, output Instruction);

endinterface

// File: rtl/instruction_fetch_stage_if_id_register.sv
// ---------------------------------------------------------------------------
// if_id_register
// IF/ID pipeline flop set.
//   clk, reset : clock, synchronous active-high reset
//   op_i       : IFID_LOAD captures pc_i/inst_i as valid, IFID_FLUSH loads a
//                bubble (PC 0, NOP, invalid), IFID_HOLD keeps contents
//   pc_i/inst_i: PC and instruction being fetched this cycle
//   pc_o/inst_o/valid_o : registered IF/ID contents
// ---------------------------------------------------------------------------
module if_id_register
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  ifid_op_t        op_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [ILEN-1:0] inst_i,
   output logic [XLEN-1:0] pc_o,
   output logic [ILEN-1:0] inst_o,
   output logic            valid_o
);

   logic [XLEN-1:0] pc_q;
   logic [ILEN-1:0] inst_q;
   logic            valid_q;

   // IF/ID storage: reset and flush both leave a bubble behind.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q    <= 64'd0;
         inst_q  <= NOP_INST;
         valid_q <= 1'b0;
      end else begin
         case (op_i)
            IFID_LOAD: begin
               pc_q    <= pc_i;
               inst_q  <= inst_i;
               valid_q <= 1'b1;
            end
            IFID_HOLD: begin
               pc_q    <= pc_q;
               inst_q  <= inst_q;
               valid_q <= valid_q;
            end
            default: begin
               pc_q    <= 64'd0;
               inst_q  <= NOP_INST;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc_o    = pc_q;
   assign inst_o  = inst_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
// Owns the PC and fetch FSM {RUN, HALT, ERR}; fetches from instruction memory
// and fills the IF/ID register. Priority per edge: reset > Branch_Taken >
// Stall > normal advance.
//   clk, reset        : clock, synchronous active-high reset
//   Stall             : hold PC, IF/ID, state and Fetch_Count
//   Branch_Taken      : redirect to Branch_Target, squashing the fetch
//   Branch_Target     : redirect address
//   imem              : Inst_Address out / Instruction in (combinational)
//   IFID_PC/Instruction/Valid : IF/ID register contents
//   Halted, Misalign_Err      : registered state decodes
//   Fetch_Count       : valid instructions delivered, saturating
// ---------------------------------------------------------------------------
module instruction_fetch_stage
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 64'd0,
   parameter int unsigned     MEM_BYTES = 120
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       Stall,
   input  logic                       Branch_Taken,
   input  logic [XLEN-1:0]            Branch_Target,
   instruction_fetch_stage_if.master  imem,
   output logic [XLEN-1:0]            IFID_PC,
   output logic [ILEN-1:0]            IFID_Instruction,
   output logic                       IFID_Valid,
   output logic                       Halted,
   output logic                       Misalign_Err,
   output logic [31:0]                Fetch_Count
);

   localparam logic [XLEN-1:0] LAST_ADDR = 64'(MEM_BYTES) - 64'd4;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     count_q, count_d;
   logic            halted_q, err_q;
   ifid_op_t        ifid_op_s;
   logic [XLEN-1:0] pc_plus4_s;

   assign pc_plus4_s = pc_q + 64'd4;

   // Memory address: parked at 0 outside RUN so out-of-range bytes are never read.
   always_comb begin
      if (state_q == RUN) begin
         imem.Inst_Address = pc_q;
      end else begin
         imem.Inst_Address = 64'd0;
      end
   end

   // Next-state logic for PC, FSM, fetch counter and IF/ID control.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      count_d   = count_q;
      ifid_op_s = IFID_HOLD;
      if (reset) begin
         pc_d      = RESET_PC;
         count_d   = 32'd0;
         ifid_op_s = IFID_FLUSH;
         if (past_end(RESET_PC, LAST_ADDR)) begin
            state_d = HALT;
         end else begin
            state_d = RUN;
         end
      end else begin
         case (state_q)
            RUN, HALT: begin
               if (Branch_Taken) begin
                  ifid_op_s = IFID_FLUSH;
                  if (Branch_Target[1:0] != 2'b00) begin
                     state_d = ERR;
                  end else if (past_end(Branch_Target, LAST_ADDR)) begin
                     pc_d    = Branch_Target;
                     state_d = HALT;
                  end else begin
                     pc_d    = Branch_Target;
                     state_d = RUN;
                  end
               end else if (Stall) begin
                  ifid_op_s = IFID_HOLD;
               end else if (state_q == RUN) begin
                  ifid_op_s = IFID_LOAD;
                  pc_d      = pc_plus4_s;
                  if (count_q != 32'hFFFF_FFFF) begin
                     count_d = count_q + 32'd1;
                  end else begin
                     count_d = count_q;
                  end
                  if (past_end(pc_plus4_s, LAST_ADDR)) begin
                     state_d = HALT;
                  end else begin
                     state_d = RUN;
                  end
               end else begin
                  // HALT drains the pipeline with bubbles.
                  ifid_op_s = IFID_FLUSH;
               end
            end
            ERR: begin
               ifid_op_s = IFID_FLUSH;
            end
            default: begin
               // Illegal encoding: fail safe into the sticky error state.
               ifid_op_s = IFID_FLUSH;
               state_d   = ERR;
            end
         endcase
      end
   end

   // State, PC, counter and registered status flags.
   always_ff @(posedge clk) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= (state_d == HALT);
      err_q    <= (state_d == ERR);
   end

   if_id_register u_if_id (
      .clk     (clk),
      .reset   (reset),
      .op_i    (ifid_op_s),
      .pc_i    (pc_q),
      .inst_i  (imem.Instruction),
      .pc_o    (IFID_PC),
      .inst_o  (IFID_Instruction),
      .valid_o (IFID_Valid)
   );

   assign Halted       = halted_q;
   assign Misalign_Err = err_q;
   assign Fetch_Count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;
   import riscv_pkg::*;

   logic            clk;
   logic            reset;
   logic            Stall;
   logic            Branch_Taken;
   logic [63:0]     Branch_Target;
   logic [63:0]     IFID_PC;
   logic [31:0]     IFID_Instruction;
   logic            IFID_Valid;
   logic            Halted;
   logic            Misalign_Err;
   logic [31:0]     Fetch_Count;

   int tests_run;
   int tests_failed;

   instruction_fetch_stage_if mem_if ();

   // Program image: fixed words at 0 and 4, addi x1,x0,addr elsewhere,
   // poison beyond the last word so illegal reads would show up.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a > 64'd116 || a[1:0] != 2'b00) return 32'hDEADBEEF;
      if (a == 64'd0) return 32'h00000513;
      if (a == 64'd4) return 32'h01400593;
      return {a[11:0], 5'd0, 3'd0, 5'd1, 7'h13};
   endfunction

   assign mem_if.Instruction = mem_word(mem_if.Inst_Address);

   instruction_fetch_stage #(.RESET_PC(64'd0), .MEM_BYTES(120)) dut (
      .clk              (clk),
      .reset            (reset),
      .Stall            (Stall),
      .Branch_Taken     (Branch_Taken),
      .Branch_Target    (Branch_Target),
      .imem             (mem_if.master),
      .IFID_PC          (IFID_PC),
      .IFID_Instruction (IFID_Instruction),
      .IFID_Valid       (IFID_Valid),
      .Halted           (Halted),
      .Misalign_Err     (Misalign_Err),
      .Fetch_Count      (Fetch_Count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 64'd0;
      step(); step();
      reset = 1'b0;
      tests_run++; if (IFID_PC !== 64'd0) begin tests_failed++; $display("FAIL reset_pc: got %0h want 0", IFID_PC); end
      tests_run++; if (IFID_Instruction !== 32'h00000013) begin tests_failed++; $display("FAIL reset_inst: got %h want 00000013", IFID_Instruction); end
      tests_run++; if (IFID_Valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", IFID_Valid); end
      tests_run++; if (Fetch_Count !== 32'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", Fetch_Count); end
      tests_run++; if (Halted !== 1'b0 || Misalign_Err !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got halt %b err %b want 0 0", Halted, Misalign_Err); end
      tests_run++; if (mem_if.Inst_Address !== 64'd0) begin tests_failed++; $display("FAIL reset_addr: got %0h want 0", mem_if.Inst_Address); end
   endtask

   task automatic test_free_run();
      step();
      tests_run++; if (IFID_PC !== 64'd0 || IFID_Instruction !== 32'h00000513 || IFID_Valid !== 1'b1) begin tests_failed++; $display("FAIL run_c1: got pc %0h inst %h v %b want 0 00000513 1", IFID_PC, IFID_Instruction, IFID_Valid); end
      step();
      tests_run++; if (IFID_PC !== 64'd4 || IFID_Instruction !== 32'h01400593 || IFID_Valid !== 1'b1) begin tests_failed++; $display("FAIL run_c2: got pc %0h inst %h v %b want 4 01400593 1", IFID_PC, IFID_Instruction, IFID_Valid); end
      tests_run++; if (Fetch_Count !== 32'd2) begin tests_failed++; $display("FAIL run_count: got %0d want 2", Fetch_Count); end
      step();
      tests_run++; if (IFID_PC !== 64'd8 || mem_if.Inst_Address !== 64'd12) begin tests_failed++; $display("FAIL run_c3: got pc %0h addr %0h want 8 c", IFID_PC, mem_if.Inst_Address); end
   endtask

   task automatic test_stall();
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++; if (IFID_PC !== 64'd8 || Fetch_Count !== 32'd3 || mem_if.Inst_Address !== 64'd12 || IFID_Valid !== 1'b1) begin tests_failed++; $display("FAIL stall_hold%0d: got pc %0h cnt %0d addr %0h v %b want 8 3 c 1", i, IFID_PC, Fetch_Count, mem_if.Inst_Address, IFID_Valid); end
      end
      Stall = 1'b0;
      step();
      tests_run++; if (IFID_PC !== 64'd12 || IFID_Instruction !== 32'h00C00093 || Fetch_Count !== 32'd4) begin tests_failed++; $display("FAIL stall_resume: got pc %0h inst %h cnt %0d want c 00c00093 4", IFID_PC, IFID_Instruction, Fetch_Count); end
   endtask

   task automatic test_halt();
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         if (IFID_PC == 64'd116) found = 1'b1;
      end
      tests_run++; if (!found) begin tests_failed++; $display("FAIL halt_reach: got pc %0h want 74 within 40 cycles", IFID_PC); end
      tests_run++; if (Halted !== 1'b1 || mem_if.Inst_Address !== 64'd0) begin tests_failed++; $display("FAIL halt_flag: got halt %b addr %0h want 1 0", Halted, mem_if.Inst_Address); end
      tests_run++; if (Fetch_Count !== 32'd30) begin tests_failed++; $display("FAIL halt_count: got %0d want 30", Fetch_Count); end
      step();
      tests_run++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h00000013 || Halted !== 1'b1) begin tests_failed++; $display("FAIL halt_drain: got v %b inst %h halt %b want 0 00000013 1", IFID_Valid, IFID_Instruction, Halted); end
   endtask

   task automatic test_branch_from_halt();
      Branch_Taken = 1'b1; Branch_Target = 64'd56;
      step();
      Branch_Taken = 1'b0;
      tests_run++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h00000013 || Halted !== 1'b0 || mem_if.Inst_Address !== 64'd56) begin tests_failed++; $display("FAIL bhalt_bubble: got v %b inst %h halt %b addr %0h want 0 00000013 0 38", IFID_Valid, IFID_Instruction, Halted, mem_if.Inst_Address); end
      step();
      tests_run++; if (IFID_PC !== 64'd56 || IFID_Valid !== 1'b1 || IFID_Instruction !== 32'h03800093) begin tests_failed++; $display("FAIL bhalt_target: got pc %0h v %b inst %h want 38 1 03800093", IFID_PC, IFID_Valid, IFID_Instruction); end
   endtask

   task automatic test_branch_and_stall();
      Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 64'd48;
      step();
      Stall = 1'b0; Branch_Taken = 1'b0;
      tests_run++; if (IFID_Valid !== 1'b0 || mem_if.Inst_Address !== 64'd48 || Fetch_Count !== 32'd31) begin tests_failed++; $display("FAIL bstall_bubble: got v %b addr %0h cnt %0d want 0 30 31", IFID_Valid, mem_if.Inst_Address, Fetch_Count); end
      step();
      tests_run++; if (IFID_PC !== 64'd48 || IFID_Valid !== 1'b1 || Fetch_Count !== 32'd32) begin tests_failed++; $display("FAIL bstall_target: got pc %0h v %b cnt %0d want 30 1 32", IFID_PC, IFID_Valid, Fetch_Count); end
   endtask

   task automatic test_branch_past_end();
      Branch_Taken = 1'b1; Branch_Target = 64'd200;
      step();
      tests_run++; if (Halted !== 1'b1 || mem_if.Inst_Address !== 64'd0 || IFID_Valid !== 1'b0) begin tests_failed++; $display("FAIL bend_halt: got halt %b addr %0h v %b want 1 0 0", Halted, mem_if.Inst_Address, IFID_Valid); end
      Branch_Target = 64'd116;
      step();
      Branch_Taken = 1'b0;
      tests_run++; if (Halted !== 1'b0 || mem_if.Inst_Address !== 64'd116) begin tests_failed++; $display("FAIL bend_last: got halt %b addr %0h want 0 74", Halted, mem_if.Inst_Address); end
      step();
      tests_run++; if (IFID_PC !== 64'd116 || IFID_Valid !== 1'b1 || Halted !== 1'b1 || mem_if.Inst_Address !== 64'd0) begin tests_failed++; $display("FAIL bend_final: got pc %0h v %b halt %b addr %0h want 74 1 1 0", IFID_PC, IFID_Valid, Halted, mem_if.Inst_Address); end
   endtask

   task automatic test_misalign();
      Branch_Taken = 1'b1; Branch_Target = 64'h3A;
      step();
      tests_run++; if (Misalign_Err !== 1'b1 || Halted !== 1'b0 || IFID_Valid !== 1'b0 || mem_if.Inst_Address !== 64'd0) begin tests_failed++; $display("FAIL mis_enter: got err %b halt %b v %b addr %0h want 1 0 0 0", Misalign_Err, Halted, IFID_Valid, mem_if.Inst_Address); end
      Branch_Target = 64'd8;
      step(); step();
      Branch_Taken = 1'b0;
      tests_run++; if (Misalign_Err !== 1'b1 || mem_if.Inst_Address !== 64'd0 || IFID_Valid !== 1'b0) begin tests_failed++; $display("FAIL mis_sticky: got err %b addr %0h v %b want 1 0 0", Misalign_Err, mem_if.Inst_Address, IFID_Valid); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests_run++; if (Misalign_Err !== 1'b0 || mem_if.Inst_Address !== 64'd0 || Fetch_Count !== 32'd0) begin tests_failed++; $display("FAIL mis_reset: got err %b addr %0h cnt %0d want 0 0 0", Misalign_Err, mem_if.Inst_Address, Fetch_Count); end
      step();
      tests_run++; if (IFID_PC !== 64'd0 || IFID_Valid !== 1'b1 || IFID_Instruction !== 32'h00000513) begin tests_failed++; $display("FAIL mis_refetch: got pc %0h v %b inst %h want 0 1 00000513", IFID_PC, IFID_Valid, IFID_Instruction); end
   endtask

   task automatic test_reset_priority();
      step();
      reset = 1'b1; Stall = 1'b1; Branch_Taken = 1'b1; Branch_Target = 64'd48;
      step();
      reset = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;
      tests_run++; if (mem_if.Inst_Address !== 64'd0 || IFID_Valid !== 1'b0 || Fetch_Count !== 32'd0 || IFID_PC !== 64'd0) begin tests_failed++; $display("FAIL rst_prio: got addr %0h v %b cnt %0d pc %0h want 0 0 0 0", mem_if.Inst_Address, IFID_Valid, Fetch_Count, IFID_PC); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_free_run();
      test_stall();
      test_halt();
      test_branch_from_halt();
      test_branch_and_stall();
      test_branch_past_end();
      test_misalign();
      test_reset_priority();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
